// File: rtl/mips_cpu_muldiv.sv
// Iterative 32-bit multiply/divide unit holding the architectural HI/LO pair.
// MULT/MULTU use LSB-first shift-add and DIV/DIVU use MSB-first restoring
// division. Both run on unsigned magnitudes, and the sign is fixed up in FIN.
// MTHI/MTLO write HI/LO directly at the accepting edge.
module mips_cpu_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic        is_div_q;
    logic        neg_res_q;   // negate product, or negate quotient
    logic        neg_rem_q;   // remainder follows the dividend sign
    logic        dz_q;        // divide by zero
    logic [31:0] src_a_q;     // raw rs, returned in HI on divide by zero
    logic [31:0] opnd_q;      // multiplicand or divisor magnitude
    logic [63:0] work_q;      // product accumulator, or dividend/quotient shifter in [31:0]
    logic [31:0] rem_q;       // partial remainder, always below the divisor
    logic        busy_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // Datapath for one iteration, plus the sign-corrected results used in FIN
    logic [32:0] mul_sum;
    logic [32:0] div_shift;   // 33-bit trial partial remainder
    logic [33:0] div_diff;
    logic        div_ok;
    logic [63:0] work_d;
    logic [31:0] rem_d;
    logic [63:0] mul_res;
    logic [31:0] quo_res;
    logic [31:0] rem_res;
    logic        sgn_in;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    // Next-state datapath for one iteration, and the FIN sign fixup
    always_comb begin
        mul_sum   = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
        div_shift = {rem_q, work_q[31]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
        div_ok    = ~div_diff[33];
        work_d    = work_q;
        rem_d     = rem_q;
        if (is_div_q) begin
            work_d = {32'd0, work_q[30:0], div_ok};
            rem_d  = div_ok ? div_diff[31:0] : div_shift[31:0];
        end else begin
            work_d = {mul_sum, work_q[31:1]};
        end

        mul_res = neg_res_q ? (64'd0 - work_q) : work_q;
        quo_res = neg_res_q ? (32'd0 - work_q[31:0]) : work_q[31:0];
        rem_res = neg_rem_q ? (32'd0 - rem_q) : rem_q;

        // Signed ops (op[0]=1) work on magnitudes
        sgn_in = op[0];
        mag_a  = (sgn_in && a[31]) ? (32'd0 - a) : a;
        mag_b  = (sgn_in && b[31]) ? (32'd0 - b) : b;
    end

    // Control FSM, operand latching and HI/LO commit
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            src_a_q   <= 32'd0;
            opnd_q    <= 32'd0;
            work_q    <= 64'd0;
            rem_q     <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULTU, OP_MULT: begin
                                is_div_q  <= 1'b0;
                                neg_res_q <= sgn_in & (a[31] ^ b[31]);
                                neg_rem_q <= 1'b0;
                                dz_q      <= 1'b0;
                                src_a_q   <= a;
                                opnd_q    <= mag_a;
                                work_q    <= {32'd0, mag_b};
                                rem_q     <= 32'd0;
                                cnt_q     <= 5'd31;
                                busy_q    <= 1'b1;
                                state_q   <= S_RUN;
                            end
                            OP_DIVU, OP_DIV: begin
                                is_div_q  <= 1'b1;
                                neg_res_q <= sgn_in & (a[31] ^ b[31]);
                                neg_rem_q <= sgn_in & a[31];
                                dz_q      <= (b == 32'd0);
                                src_a_q   <= a;
                                opnd_q    <= mag_b;
                                work_q    <= {32'd0, mag_a};
                                rem_q     <= 32'd0;
                                cnt_q     <= 5'd31;
                                busy_q    <= 1'b1;
                                state_q   <= S_RUN;
                            end
                            OP_MTHI: begin
                                hi_q   <= a;
                                done_q <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo_q   <= a;
                                done_q <= 1'b1;
                            end
                            default: begin
                                // Reserved ops are dropped without any effect
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    work_q <= work_d;
                    rem_q  <= rem_d;
                    if (cnt_q == 5'd0) begin
                        state_q <= S_FIN;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                S_FIN: begin
                    if (!is_div_q) begin
                        hi_q <= mul_res[63:32];
                        lo_q <= mul_res[31:0];
                    end else if (dz_q) begin
                        hi_q <= src_a_q;
                        lo_q <= 32'hFFFF_FFFF;
                    end else begin
                        hi_q <= rem_res;
                        lo_q <= quo_res;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Scoreboard bench for mips_cpu_muldiv. Stimulus pushes the expected {HI,LO}
// and a separate monitor pops and compares whenever done pulses.
module tb_mips_cpu_muldiv;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [63:0] v;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   done_seen  = 0;

    mips_cpu_muldiv dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run must always terminate
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: each done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_seen++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done with hi=%h lo=%h, expected no done", hi, lo);
            end else begin
                e = sb.pop_front();
                check({e.name, " result"}, {hi, lo}, e.v);
            end
        end
    end

    // Issue a mult/div op now, then wait for its done pulse and check timing
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] xa,
                          input logic [31:0] xb, input logic [63:0] exp);
        int clocks;
        int busy_n;
        logic got;
        exp_t e;
        e.v = exp;
        e.name = name;
        sb.push_back(e);
        start = 1'b1; op = o; a = xa; b = xb;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        clocks = 0; busy_n = 0; got = 1'b0;
        while (!got && clocks < 100) begin
            @(negedge clk);
            clocks++;
            if (done === 1'b1) got = 1'b1;
            else if (busy === 1'b1) busy_n++;
        end
        check({name, " latency"}, 64'(clocks), 64'd34);
        check({name, " busy_cycles"}, 64'(busy_n), 64'd33);
    endtask

    initial begin
        int base;
        int i;
        exp_t e;
        reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);

        // Back-to-back mult/div: each run_op issues in the previous done cycle
        run_op("multu_ffffffff_3", 3'b000, 32'hFFFF_FFFF, 32'd3, 64'h00000002_FFFFFFFD);
        run_op("mult_m1_3",        3'b001, 32'hFFFF_FFFF, 32'd3, 64'hFFFFFFFF_FFFFFFFD);
        run_op("mult_min_min",     3'b001, 32'h8000_0000, 32'h8000_0000, 64'h40000000_00000000);
        run_op("div_m7_2",         3'b011, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        run_op("div_min_m1",       3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000);
        run_op("div_7_m2",         3'b011, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD);
        run_op("divu_7_0",         3'b010, 32'd7, 32'd0, 64'h00000007_FFFFFFFF);
        run_op("div_m7_0",         3'b011, 32'hFFFF_FFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF);

        // MTHI then MTLO on consecutive cycles
        e.v = 64'h12345678_FFFFFFFF; e.name = "mthi"; sb.push_back(e);
        e.v = 64'h12345678_9ABCDEF0; e.name = "mtlo"; sb.push_back(e);
        start = 1'b1; op = 3'b100; a = 32'h1234_5678;
        @(posedge clk);
        #1;
        base = done_seen;
        check("mthi busy", {63'd0, busy}, 64'd0);
        op = 3'b101; a = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("mtlo busy", {63'd0, busy}, 64'd0);
        repeat (4) @(negedge clk);
        check("mt done count", 64'(done_seen - base), 64'd2);

        // Reserved op: no state change and no done
        base = done_seen;
        start = 1'b1; op = 3'b110; a = 32'h1111_1111; b = 32'h2222_2222;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("reserved busy", {63'd0, busy}, 64'd0);
        repeat (5) @(negedge clk);
        check("reserved done count", 64'(done_seen - base), 64'd0);
        check("reserved hilo", {hi, lo}, 64'h12345678_9ABCDEF0);

        // DIVU 100/7 with an ignored start and changed operands at RUN cycle 5
        e.v = 64'h00000002_0000000E; e.name = "divu_100_7_robust"; sb.push_back(e);
        base = done_seen;
        start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        i = 0;
        while (done !== 1'b1 && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("robust done reached", {63'd0, done}, 64'd1);
        repeat (40) @(negedge clk);
        check("robust done count", 64'(done_seen - base), 64'd1);

        // MULTU aborted by reset at cycle 10; reset beats a simultaneous MTHI
        start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        base = done_seen;
        reset = 1'b1; start = 1'b1; op = 3'b100; a = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        reset = 1'b0; start = 1'b0;
        check("abort hilo", {hi, lo}, 64'd0);
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort done", {63'd0, done}, 64'd0);
        repeat (40) @(negedge clk);
        check("abort done count", 64'(done_seen - base), 64'd0);

        run_op("divu_100_7", 3'b010, 32'd100, 32'd7, 64'h00000002_0000000E);

        repeat (3) @(negedge clk);
        check("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
